// File: rtl/stopwatch_core.sv
// Stopwatch / countdown engine with mm:ss-style mixed-radix digits, lap freeze,
// per-digit adjust with blink, and a registered multiplexed seven-segment driver.
module stopwatch_core #(
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 1,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 65536,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_stop,
    input  logic                      lap,
    input  logic                      dir,
    input  logic                      adj,
    input  logic [$clog2(DIGITS)-1:0] adj_sel,
    input  logic [3:0]                adj_val,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an,
    output logic                      running,
    output logic                      done
);
    localparam int TDIV = CLK_HZ / TICK_HZ;
    localparam int PW   = (TDIV > 1) ? $clog2(TDIV) : 1;
    localparam int SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW   = $clog2(DIGITS);

    typedef logic [3:0] digs_t [DIGITS];

    digs_t             dig_q, dig_nx, lap_q, lap_nx;
    logic [PW-1:0]     presc_q, presc_nx;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_nx;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_nx;
    logic [IW-1:0]     idx_q, idx_nx;
    logic              frozen_q, frozen_nx, blink_on_q, blink_on_nx;
    logic              run_nx, done_nx, tick, term, carry;
    logic [3:0]        shown;
    logic [6:0]        seg_nx;
    logic [DIGITS-1:0] an_nx;

    // Odd digits are tens-of-seconds/minutes (radix 6), even digits radix 10.
    function automatic logic [3:0] digit_max(input int i);
        return (i % 2 == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic is_zero(input digs_t d);
        logic z;
        z = 1'b1;
        for (int i = 0; i < DIGITS; i++) if (d[i] != 4'd0) z = 1'b0;
        return z;
    endfunction

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign tick = running && (presc_q == PW'(TDIV - 1));

    // NOTE: every signal written here is given a default first so no latch is inferred.
    always_comb begin
        dig_nx    = dig_q;
        lap_nx    = lap_q;
        presc_nx  = presc_q;
        run_nx    = running;
        done_nx   = done;
        frozen_nx = frozen_q;
        term      = 1'b0;
        carry     = 1'b1;
        if (adj) begin
            run_nx   = 1'b0;
            presc_nx = '0;
            for (int i = 0; i < DIGITS; i++)
                if (int'(adj_sel) == i)
                    dig_nx[i] = (adj_val > digit_max(i)) ? digit_max(i) : adj_val;
        end else begin
            if (running) presc_nx = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (!dir) begin
                            if (dig_q[i] == digit_max(i)) dig_nx[i] = 4'd0;
                            else begin dig_nx[i] = dig_q[i] + 4'd1; carry = 1'b0; end
                        end else begin
                            if (dig_q[i] == 4'd0) dig_nx[i] = digit_max(i);
                            else begin dig_nx[i] = dig_q[i] - 4'd1; carry = 1'b0; end
                        end
                    end
                end
                term = dir && is_zero(dig_nx);
            end
            if (start_stop) begin
                if (running) run_nx = 1'b0;
                else if (!(dir && is_zero(dig_q))) begin
                    run_nx  = 1'b1;
                    done_nx = 1'b0;
                end
            end
            if (term) begin
                run_nx  = 1'b0;
                done_nx = 1'b1;
            end
        end
        // Any stop releases the display; otherwise lap toggles the freeze.
        if (running && !run_nx) frozen_nx = 1'b0;
        else if (lap) begin
            if (frozen_q) frozen_nx = 1'b0;
            else if (running) begin
                frozen_nx = 1'b1;
                lap_nx    = dig_q;
            end
        end
    end

    always_comb begin
        scan_cnt_nx  = (scan_cnt_q == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + SW'(1);
        idx_nx       = idx_q;
        if (scan_cnt_q == SW'(SCAN_DIV - 1))
            idx_nx = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        blink_cnt_nx = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BW'(1);
        blink_on_nx  = (blink_cnt_q == BW'(BLINK_DIV - 1)) ? ~blink_on_q : blink_on_q;
    end

    // Display registers are loaded from next-state values so seg/an track the new index.
    always_comb begin
        shown = 4'd0;
        for (int i = 0; i < DIGITS; i++)
            if (idx_nx == IW'(i)) shown = frozen_nx ? lap_nx[i] : dig_nx[i];
        seg_nx = (adj && (adj_sel == idx_nx) && !blink_on_nx) ? 7'h7F : hex7(shown);
        an_nx  = ~(DIGITS'(1) << idx_nx);
    end

    // NOTE: state uses non-blocking assignments only; the small digit arrays are reset too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q       <= '{default: 4'd0};
            lap_q       <= '{default: 4'd0};
            presc_q     <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            frozen_q    <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            seg         <= 7'b1000000;
            an          <= ~DIGITS'(1);
        end else begin
            dig_q       <= dig_nx;
            lap_q       <= lap_nx;
            presc_q     <= presc_nx;
            running     <= run_nx;
            done        <= done_nx;
            frozen_q    <= frozen_nx;
            scan_cnt_q  <= scan_cnt_nx;
            idx_q       <= idx_nx;
            blink_cnt_q <= blink_cnt_nx;
            blink_on_q  <= blink_on_nx;
            seg         <= seg_nx;
            an          <= an_nx;
        end
    end
endmodule
